// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, idle line level and accumulator sizing for the buffered UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    localparam logic UART_IDLE_LVL = 1'b1;
    function automatic int acc_width(input int clk_hz);
        return $clog2(clk_hz) + 1;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered level/full/empty and first-word read data
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_d;
    logic do_push, do_pop;
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign level_d = wr_ptr_d - rd_ptr_d;
    assign data_o = mem_q[rd_ptr_q[AW-1:0]];
    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_o <= '0;
            full_o <= 1'b0;
            empty_o <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_o <= level_d;
            full_o <= level_d == FULL_LVL;
            empty_o <= level_d == '0;
        end
    end
    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; define UART_TX_PARITY_EN to add a parity bit
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic                         tx_valid_i,
    input  logic [DATA_BITS-1:0]         tx_data_i,
    output logic                         tx_ready_o,
    output logic                         uart_tx_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (2 * BAUD >= CLK_HZ) begin : g_bad_baud
        $error("BAUD must be below CLK_HZ/2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("PARITY_ODD must be 0 or 1");
    end
    localparam int ACC_W = acc_width(CLK_HZ);
    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(BAUD);
    localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_HZ);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    logic [ACC_W-1:0] acc_q, acc_sum, acc_d;
    logic tick, pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_data, shift_q;
    logic [3:0] bit_cnt_q;
    logic stop_cnt_q, tx_q, busy_q;
    uart_state_e state_q;
`ifdef UART_TX_PARITY_EN
    logic par_q;
`endif
    assign acc_sum = acc_q + ACC_INC;
    assign tick = acc_sum >= ACC_MOD;
    assign acc_d = tick ? acc_sum - ACC_MOD : acc_sum;
    assign pop = tick && !fifo_empty && (state_q == IDLE || (state_q == STOP && stop_cnt_q == LAST_STOP));
    assign tx_ready_o = !fifo_full;
    assign uart_tx_o = tx_q;
    assign busy_o = busy_q;
    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk_i   (sys_clk_i),
        .rst_i   (sys_rst_i),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .level_o (fifo_level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    // Fractional baud accumulator: wrapping by CLK_HZ makes ticks average exactly BAUD per second
    always_ff @(posedge sys_clk_i) begin
        acc_q <= sys_rst_i ? '0 : acc_d;
    end
    // Frame sequencer: advances only on ticks, so every line transition lands in the cycle after a tick
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            tx_q <= UART_IDLE_LVL;
            shift_q <= '0;
            bit_cnt_q <= '0;
            stop_cnt_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            busy_q <= state_q != IDLE || !fifo_empty;
            if (pop) begin
                shift_q <= fifo_data;
                tx_q <= 1'b0;
                state_q <= START;
`ifdef UART_TX_PARITY_EN
                par_q <= ^fifo_data ^ PARITY_ODD[0];
`endif
            end else if (tick) begin
                case (state_q)
                    START: begin
                        tx_q <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q <= DATA;
                    end
                    DATA: begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            tx_q <= par_q;
                            state_q <= PARITY;
`else
                            tx_q <= UART_IDLE_LVL;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    PARITY: begin
                        tx_q <= UART_IDLE_LVL;
                        stop_cnt_q <= 1'b0;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (stop_cnt_q == LAST_STOP) state_q <= IDLE;
                        else stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                    default: begin
                        tx_q <= UART_IDLE_LVL;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
